// File: rtl/p405s_timer_status.sv
// p405s_timer_status: Timer Status Register (TSR) for the PIT, FIT and watchdog timers.
//
// Keeps the TSR state bits, runs the watchdog {ENW,WIS} state machine and drives the
// level interrupt requests. Software clears TSR bits by writing ones (write-one-to-clear).
// A hardware set wins over a software clear of the same bit in the same cycle.
//
// Ports
//   CB               in   clock, rising edge
//   RST              in   asynchronous, active-high reset
//   hwSetPitStatus   in   PIT expiry pulse (sets PIS)
//   hwSetFitStatus   in   FIT expiry pulse (sets FIS)
//   wdEvent          in   watchdog period pulse (advances the watchdog state machine)
//   freezeTimersNEG  in   low = ignore all hardware events
//   PCL_mtSPR        in   mtSPR strobe
//   PCL_sprHold      in   SPR write hold
//   tsrDcd           in   TSR address decode
//   EXE_sprDataBus   in   [0:31] mtSPR data
//   tcrPie/Fie/Wie   in   interrupt enables from TCR
//   tcrWrc           in   [0:1] watchdog reset control from TCR
//   tsrL2            out  [0:31] TSR: 0 ENW, 1 WIS, 2:3 WRS, 4 PIS, 5 FIS, 6:31 zero
//   pitIntReq        out  PIS & tcrPie
//   fitIntReq        out  FIS & tcrFie
//   wdIntReq         out  WIS & tcrWie
//   wdResetReq       out  [0:1] latched reset request to the reset controller, 00 = none
//
// Configuration macro
//   P405S_TSR_WD_RESET_EN  defined: the watchdog reset stage loads WRS and wdResetReq from
//                          tcrWrc. Undefined: the reset stage holds state 11, WRS reads 00
//                          and wdResetReq is tied to 00.
module p405s_timer_status (
  input  logic        CB,
  input  logic        RST,
  input  logic        hwSetPitStatus,
  input  logic        hwSetFitStatus,
  input  logic        wdEvent,
  input  logic        freezeTimersNEG,
  input  logic        PCL_mtSPR,
  input  logic        PCL_sprHold,
  input  logic        tsrDcd,
  input  logic [0:31] EXE_sprDataBus,
  input  logic        tcrPie,
  input  logic        tcrFie,
  input  logic        tcrWie,
  input  logic [0:1]  tcrWrc,
  output logic [0:31] tsrL2,
  output logic        pitIntReq,
  output logic        fitIntReq,
  output logic        wdIntReq,
  output logic [0:1]  wdResetReq
);

  // Watchdog state encoded directly as {ENW, WIS}.
  typedef enum logic [1:0] {
    WdIdle  = 2'b00,
    WdWis   = 2'b01,
    WdEnw   = 2'b10,
    WdArmed = 2'b11
  } wdState_t;

  wdState_t   wdStateQ, wdStateD, wdCleared;
  logic       pisQ, pisD;
  logic       fisQ, fisD;
  logic       tsrWrite;
  logic       wdStep;
  logic       resetStage;
  logic [1:0] wrs;

  assign tsrWrite = PCL_mtSPR & tsrDcd & ~PCL_sprHold;
  assign wdStep   = wdEvent & freezeTimersNEG;

  always_comb begin
    // Software clear is applied first; the watchdog transition acts on the cleared state.
    wdCleared  = wdState_t'(wdStateQ & ~({2{tsrWrite}} & EXE_sprDataBus[0:1]));
    wdStateD   = wdCleared;
    resetStage = 1'b0;
    if (wdStep) begin
      unique case (wdCleared)
        WdIdle:  wdStateD = WdEnw;
        WdWis:   wdStateD = WdArmed;
        WdEnw:   wdStateD = WdArmed;
        WdArmed: resetStage = 1'b1;
        default: wdStateD = wdCleared;
      endcase
    end
    // Hardware set has priority over the software clear.
    pisD = (hwSetPitStatus & freezeTimersNEG) | (pisQ & ~(tsrWrite & EXE_sprDataBus[4]));
    fisD = (hwSetFitStatus & freezeTimersNEG) | (fisQ & ~(tsrWrite & EXE_sprDataBus[5]));
  end

  always_ff @(posedge CB or posedge RST) begin
    if (RST) begin
      wdStateQ <= WdIdle;
      pisQ     <= 1'b0;
      fisQ     <= 1'b0;
    end else begin
      wdStateQ <= wdStateD;
      pisQ     <= pisD;
      fisQ     <= fisD;
    end
  end

`ifdef P405S_TSR_WD_RESET_EN
  logic [1:0] wrsQ, wrsD;
  logic [1:0] reqQ, reqD;

  always_comb begin
    wrsD = wrsQ & ~({2{tsrWrite}} & EXE_sprDataBus[2:3]);
    reqD = reqQ;
    // A pending request is sticky until reset; only the first reset stage loads it.
    if (resetStage && (tcrWrc != 2'b00) && (reqQ == 2'b00)) begin
      wrsD = tcrWrc;
      reqD = tcrWrc;
    end
  end

  always_ff @(posedge CB or posedge RST) begin
    if (RST) begin
      wrsQ <= 2'b00;
      reqQ <= 2'b00;
    end else begin
      wrsQ <= wrsD;
      reqQ <= reqD;
    end
  end

  assign wrs        = wrsQ;
  assign wdResetReq = reqQ;
`else
  logic unusedWdReset;
  assign unusedWdReset = ^{tcrWrc, EXE_sprDataBus[2:3], resetStage};
  assign wrs           = 2'b00;
  assign wdResetReq    = 2'b00;
`endif

  logic unusedDataBits;
  assign unusedDataBits = ^EXE_sprDataBus[6:31];

  assign tsrL2     = {wdStateQ, wrs, pisQ, fisQ, 26'b0};
  assign pitIntReq = pisQ & tcrPie;
  assign fitIntReq = fisQ & tcrFie;
  assign wdIntReq  = wdStateQ[0] & tcrWie;

endmodule

// File: tb/tb_p405s_timer_status.sv
module tb_p405s_timer_status;

  logic        CB = 1'b0;
  logic        RST;
  logic        hwSetPitStatus, hwSetFitStatus, wdEvent, freezeTimersNEG;
  logic        PCL_mtSPR, PCL_sprHold, tsrDcd;
  logic [0:31] EXE_sprDataBus;
  logic        tcrPie, tcrFie, tcrWie;
  logic [0:1]  tcrWrc;
  logic [0:31] tsrL2;
  logic        pitIntReq, fitIntReq, wdIntReq;
  logic [0:1]  wdResetReq;

  int total  = 0;
  int passed = 0;

`ifdef P405S_TSR_WD_RESET_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  p405s_timer_status dut (
    .CB              (CB),
    .RST             (RST),
    .hwSetPitStatus  (hwSetPitStatus),
    .hwSetFitStatus  (hwSetFitStatus),
    .wdEvent         (wdEvent),
    .freezeTimersNEG (freezeTimersNEG),
    .PCL_mtSPR       (PCL_mtSPR),
    .PCL_sprHold     (PCL_sprHold),
    .tsrDcd          (tsrDcd),
    .EXE_sprDataBus  (EXE_sprDataBus),
    .tcrPie          (tcrPie),
    .tcrFie          (tcrFie),
    .tcrWie          (tcrWie),
    .tcrWrc          (tcrWrc),
    .tsrL2           (tsrL2),
    .pitIntReq       (pitIntReq),
    .fitIntReq       (fitIntReq),
    .wdIntReq        (wdIntReq),
    .wdResetReq      (wdResetReq)
  );

  always #5 CB = ~CB;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CB);
    #1;
  endtask

  // One-cycle TSR write of the given data.
  task automatic tsrWr(input logic [31:0] data);
    PCL_mtSPR = 1'b1; tsrDcd = 1'b1; EXE_sprDataBus = data;
    step();
    PCL_mtSPR = 1'b0; tsrDcd = 1'b0; EXE_sprDataBus = '0;
  endtask

  task automatic wdPulse();
    wdEvent = 1'b1;
    step();
    wdEvent = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    hwSetPitStatus = 0; hwSetFitStatus = 0; wdEvent = 0; freezeTimersNEG = 1;
    PCL_mtSPR = 0; PCL_sprHold = 0; tsrDcd = 0; EXE_sprDataBus = '0;
    tcrPie = 0; tcrFie = 0; tcrWie = 0; tcrWrc = 2'b00;
    #12;
    check("rst_tsr", tsrL2, 32'h0);
    check("rst_wdreq", {30'b0, wdResetReq}, 32'h0);
    check("rst_ints", {29'b0, pitIntReq, fitIntReq, wdIntReq}, 32'h0);
    RST = 1'b0;
    step();

    // PIT set, interrupt, and W1C
    tcrPie = 1'b1;
    hwSetPitStatus = 1'b1; step(); hwSetPitStatus = 1'b0;
    check("pit_set_tsr", tsrL2, 32'h0800_0000);
    check("pit_int", {31'b0, pitIntReq}, 32'h1);
    tcrPie = 1'b0; #1;
    check("pit_int_gated", {31'b0, pitIntReq}, 32'h0);
    tcrPie = 1'b1;
    tsrWr(32'h0800_0000);
    check("pit_clr_tsr", tsrL2, 32'h0);
    check("pit_clr_int", {31'b0, pitIntReq}, 32'h0);

    // Write with sprHold must not clear
    hwSetPitStatus = 1'b1; step(); hwSetPitStatus = 1'b0;
    PCL_sprHold = 1'b1; tsrWr(32'h0800_0000); PCL_sprHold = 1'b0;
    check("hold_no_clr", tsrL2, 32'h0800_0000);
    tsrWr(32'h0800_0000);

    // FIT set wins over simultaneous clear
    tcrFie = 1'b1;
    hwSetFitStatus = 1'b1; tsrWr(32'h0400_0000); hwSetFitStatus = 1'b0;
    check("fit_set_wins", tsrL2, 32'h0400_0000);
    check("fit_int", {31'b0, fitIntReq}, 32'h1);
    tsrWr(32'h0400_0000);
    check("fit_clr", tsrL2, 32'h0);

    // Frozen: hardware events ignored, software still clears
    freezeTimersNEG = 1'b0;
    hwSetPitStatus = 1'b1; hwSetFitStatus = 1'b1; wdEvent = 1'b1;
    step();
    hwSetPitStatus = 1'b0; hwSetFitStatus = 1'b0; wdEvent = 1'b0;
    check("frz_ignore", tsrL2, 32'h0);
    freezeTimersNEG = 1'b1;
    hwSetPitStatus = 1'b1; step(); hwSetPitStatus = 1'b0;
    freezeTimersNEG = 1'b0;
    tsrWr(32'h0800_0000);
    check("frz_clr", tsrL2, 32'h0);
    freezeTimersNEG = 1'b1;

    // Watchdog sequence with tcrWrc=10
    tcrWrc = 2'b10; tcrWie = 1'b1;
    wdPulse();
    check("wd1_tsr", tsrL2, 32'h8000_0000);
    check("wd1_int", {31'b0, wdIntReq}, 32'h0);
    wdPulse();
    check("wd2_tsr", tsrL2, 32'hC000_0000);
    check("wd2_int", {31'b0, wdIntReq}, 32'h1);
    wdPulse();
    check("wd3_tsr", tsrL2, WdEn ? 32'hE000_0000 : 32'hC000_0000);
    check("wd3_req", {30'b0, wdResetReq}, WdEn ? 32'h2 : 32'h0);
    tcrWrc = 2'b01;
    for (int i = 0; i < 5; i++) begin
      wdPulse();
      check("wd_hold_req", {30'b0, wdResetReq}, WdEn ? 32'h2 : 32'h0);
      check("wd_hold_tsr", tsrL2, WdEn ? 32'hE000_0000 : 32'hC000_0000);
    end

    // Clearing WRS leaves the latched request alone
    tsrWr(32'h2000_0000);
    check("wrs_clr_tsr", tsrL2, 32'hC000_0000);
    check("wrs_clr_req", {30'b0, wdResetReq}, WdEn ? 32'h2 : 32'h0);

    // Software clear first, then watchdog transition
    wdEvent = 1'b1; tsrWr(32'hC000_0000); wdEvent = 1'b0;
    check("clr_then_wd_00", tsrL2, 32'h8000_0000);
    wdEvent = 1'b1; tsrWr(32'h8000_0000); wdEvent = 1'b0;
    check("clr_then_wd_10", tsrL2, 32'h8000_0000);
    check("clr_keeps_req", {30'b0, wdResetReq}, WdEn ? 32'h2 : 32'h0);

    // Asynchronous reset between edges
    #2; RST = 1'b1; #1;
    check("arst1_tsr", tsrL2, 32'h0);
    check("arst1_req", {30'b0, wdResetReq}, 32'h0);
    RST = 1'b0;
    step();

    // Reach a 11 request, then reset mid-cycle
    tcrWrc = 2'b11;
    wdPulse(); wdPulse(); wdPulse();
    check("wd11_tsr", tsrL2, WdEn ? 32'hF000_0000 : 32'hC000_0000);
    check("wd11_req", {30'b0, wdResetReq}, WdEn ? 32'h3 : 32'h0);
    #2; RST = 1'b1; #1;
    check("arst2_tsr", tsrL2, 32'h0);
    check("arst2_req", {30'b0, wdResetReq}, 32'h0);
    check("arst2_wdint", {31'b0, wdIntReq}, 32'h0);
    RST = 1'b0;
    wdPulse();
    check("post_rst_wd", tsrL2, 32'h8000_0000);
    check("post_rst_req", {30'b0, wdResetReq}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
